// File: rtl/rv32_pkg.sv
// rv32_pkg: shared constants and types for the RV32M multiply/divide unit.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    // funct3[2] separates the divide/remainder group from the multiplies
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_rs1_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_rs2_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: turns unsigned magnitudes from the iterative datapath
// into the final signed result and selects the word the op asks for.
module muldiv_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic [2:0]        i_op,
    input  logic [2*XLEN-1:0] i_prod_mag,
    input  logic [XLEN-1:0]   i_quo_mag,
    input  logic [XLEN-1:0]   i_rem_mag,
    input  logic              i_neg_res,
    input  logic              i_neg_rem,
    output logic [XLEN-1:0]   o_result
);
    import rv32_pkg::*;

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    // product and quotient follow the xor of operand signs; remainder follows the dividend
    assign w_prod = i_neg_res ? -i_prod_mag : i_prod_mag;
    assign w_quo  = i_neg_res ? -i_quo_mag  : i_quo_mag;
    assign w_rem  = i_neg_rem ? -i_rem_mag  : i_rem_mag;

    // pick low/high product word, quotient or remainder
    always_comb begin
        o_result = '0;
        if (op_is_div(i_op)) begin
            o_result = i_op[1] ? w_rem : w_quo;
        end else if (i_op == OP_MUL) begin
            o_result = w_prod[XLEN-1:0];
        end else begin
            o_result = w_prod[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M execution unit (shift-add multiply,
// restoring divide) with valid/ready handshake and pipeline flush.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready for a request; in_ready high
// ST_CALC | one multiply or divide step per cycle for XLEN cycles
// ST_DONE | result held on out_valid until downstream takes it
module muldiv_unit #(
    parameter int XLEN = rv32_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    import rv32_pkg::*;

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     r_state;
    muldiv_state_e     w_state_nxt;

    logic [2:0]        r_op;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic [XLEN-1:0]   r_a_mag;
    logic [XLEN-1:0]   r_b_mag;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic              w_last;

    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_prod_step;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [XLEN-1:0]   w_quo_step;
    logic [XLEN-1:0]   w_rem_step;
    logic [XLEN-1:0]   w_fixed;

    // flush blocks acceptance even when in_valid is presented in IDLE
    assign w_accept = in_valid && (r_state == ST_IDLE) && !flush;

    assign w_a_neg = op_rs1_signed(op) & rs1[XLEN-1];
    assign w_b_neg = op_rs2_signed(op) & rs2[XLEN-1];
    assign w_a_mag = w_a_neg ? -rs1 : rs1;
    assign w_b_mag = w_b_neg ? -rs2 : rs2;

    assign w_div_zero = op_is_div(op) && (rs2 == '0);
    assign w_div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                        (rs1 == MIN_NEG) && (rs2 == '1);
    assign w_special  = w_div_zero || w_div_ovf;

    // results that bypass iteration entirely
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = op[1] ? rs1 : '1;
        end else if (w_div_ovf) begin
            w_special_res = op[1] ? '0 : MIN_NEG;
        end
    end

    assign w_last = (r_cnt == CW'(XLEN - 1));

    // shift-add: add multiplicand into the upper half when the low bit is set, then shift right
    assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                         (r_prod[0] ? {1'b0, r_a_mag} : '0);
    assign w_prod_step = {w_mul_sum, r_prod[XLEN-1:1]};

    // restoring: shift next dividend bit into the remainder, keep the difference if non-negative
    assign w_div_shift = {r_rem, r_quo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b_mag};
    assign w_quo_step  = {r_quo[XLEN-2:0], ~w_div_diff[XLEN]};
    assign w_rem_step  = w_div_diff[XLEN] ? w_div_shift[XLEN-1:0] : w_div_diff[XLEN-1:0];

    // sign correction is fed from the final step so the result registers on the last CALC edge
    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .i_op       (r_op),
        .i_prod_mag (w_prod_step),
        .i_quo_mag  (w_quo_step),
        .i_rem_mag  (w_rem_step),
        .i_neg_res  (r_neg_res),
        .i_neg_rem  (r_neg_rem),
        .o_result   (w_fixed)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic; flush wins over completion and handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // operand capture on accept, one iteration per CALC cycle, result capture at the end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_a_mag   <= '0;
            r_b_mag   <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= op;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_a_mag   <= w_a_mag;
                        r_b_mag   <= w_b_mag;
                        r_prod    <= {{XLEN{1'b0}}, w_b_mag};
                        r_rem     <= '0;
                        r_quo     <= w_a_mag;
                        r_cnt     <= '0;
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                ST_CALC: begin
                    if (!flush) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (op_is_div(r_op)) begin
                            r_quo <= w_quo_step;
                            r_rem <= w_rem_step;
                        end else begin
                            r_prod <= w_prod_step;
                        end
                        if (w_last) begin
                            r_result <= w_fixed;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_CALC) || (r_state == ST_DONE);
    assign result    = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against
// an arithmetic reference model.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // RV32M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] t_op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          ub_s;
        longint          p;
        longint unsigned pu;
        logic [31:0]     r;
        sa   = $signed(a);
        sb   = $signed(b);
        ub_s = longint'({32'h0, b});
        r    = '0;
        case (t_op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub_s; r = p[63:32]; end
            3'd3: begin pu = {32'h0, a} * {32'h0, b}; r = pu[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [2:0] t_op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if (t_op[2] && b == 0) return 1;
        if ((t_op == 3'd4 || t_op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // present a request and take the accepting edge; operands are then scrambled
    task automatic start_op(input logic [2:0] t_op, input logic [31:0] a, input logic [31:0] b);
        op       = t_op;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op       = 3'($urandom_range(0, 7));
        rs1      = $urandom;
        rs2      = $urandom;
    endtask

    // count edges (accept edge = 1) until out_valid, tracking busy along the way
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 1;
        busy_ok = busy;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            busy_ok = busy_ok & busy;
        end
    endtask

    // full transaction; during DONE a new request is offered to expose any same-cycle re-accept
    task automatic run_op(input logic [2:0] t_op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat,
                          output bit busy_ok, output bit hs_ok);
        out_ready = 1'b0;
        start_op(t_op, a, b);
        wait_done(lat, busy_ok);
        res       = result;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        hs_ok     = in_ready && !out_valid && !busy;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (result !== 32'h0)   begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        vec_t        v[12];
        logic [31:0] res;
        int          lat;
        bit          bok, hok;
        v[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        v[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        v[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[3]  = '{3'd2, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF};
        v[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        v[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        v[6]  = '{3'd7, 32'd7,          32'hFFFF_FFFE, 32'd7};
        v[7]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        v[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
        v[9]  = '{3'd6, 32'd5,          32'd0,         32'd5};
        v[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        v[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
        for (int i = 0; i < 12; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, res, lat, bok, hok);
            n_cmp++; if (res !== v[i].exp) begin n_err++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, v[i].exp); end
            n_cmp++; if (lat != exp_latency(v[i].op, v[i].a, v[i].b)) begin n_err++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, exp_latency(v[i].op, v[i].a, v[i].b)); end
            n_cmp++; if (!bok) begin n_err++; $display("FAIL directed_busy[%0d]: busy dropped while operation in flight", i); end
            n_cmp++; if (!hok) begin n_err++; $display("FAIL directed_handshake[%0d]: got in_ready=%b out_valid=%b busy=%b want 1/0/0", i, in_ready, out_valid, busy); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  t_op;
        logic [31:0] a, b, res, exp;
        int          lat;
        bit          bok, hok;
        for (int i = 0; i < 60; i++) begin
            t_op = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 40) - 20; b = $urandom_range(0, 10) - 5; end
                3: a = 32'h0;
                default: ;
            endcase
            exp = ref_model(t_op, a, b);
            run_op(t_op, a, b, res, lat, bok, hok);
            n_cmp++; if (res !== exp) begin n_err++; $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, t_op, a, b, res, exp); end
            n_cmp++; if (lat != exp_latency(t_op, a, b)) begin n_err++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, exp_latency(t_op, a, b)); end
            n_cmp++; if (!hok) begin n_err++; $display("FAIL random_handshake[%0d]: in_ready=%b out_valid=%b busy=%b", i, in_ready, out_valid, busy); end
        end
    endtask

    task automatic test_hold();
        logic [31:0] a, b, exp;
        int          lat;
        bit          bok;
        a   = $urandom;
        b   = $urandom;
        exp = ref_model(3'd1, a, b);
        out_ready = 1'b0;
        start_op(3'd1, a, b);
        wait_done(lat, bok);
        n_cmp++; if (lat != 33) begin n_err++; $display("FAIL hold_latency: got %0d want 33", lat); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (result !== exp)    begin n_err++; $display("FAIL hold_result[%0d]: got %h want %h", i, result, exp); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_out_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (!(in_ready === 1'b1 && out_valid === 1'b0)) begin n_err++; $display("FAIL hold_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] a, b, res, exp;
        int          lat;
        bit          bok, hok, seen;
        a = $urandom;
        b = $urandom | 32'h1;
        out_ready = 1'b1;
        start_op(3'd4, a, b);
        repeat (11) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++; if (!(busy === 1'b0 && in_ready === 1'b1 && out_valid === 1'b0)) begin n_err++; $display("FAIL flush_calc: got busy=%b in_ready=%b out_valid=%b want 0/1/0", busy, in_ready, out_valid); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_err++; $display("FAIL flush_no_result: got out_valid pulse want none"); end

        out_ready = 1'b0;
        start_op(3'd0, $urandom, $urandom);
        wait_done(lat, bok);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++; if (!(out_valid === 1'b0 && busy === 1'b0)) begin n_err++; $display("FAIL flush_done: got out_valid=%b busy=%b want 0/0", out_valid, busy); end

        in_valid = 1'b1; flush = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        n_cmp++; if (!(busy === 1'b0 && in_ready === 1'b1)) begin n_err++; $display("FAIL flush_idle_reject: got busy=%b in_ready=%b want 0/1", busy, in_ready); end

        a   = $urandom;
        b   = $urandom | 32'h1;
        exp = ref_model(3'd6, a, b);
        run_op(3'd6, a, b, res, lat, bok, hok);
        n_cmp++; if (res !== exp) begin n_err++; $display("FAIL flush_after_op: got %h want %h", res, exp); end
    endtask

    task automatic test_rst_mid();
        logic [31:0] res, a, b, exp;
        int          lat;
        bit          bok, hok;
        run_op(3'd0, 32'd3, 32'd5, res, lat, bok, hok);
        n_cmp++; if (res !== 32'd15) begin n_err++; $display("FAIL rst_pre_op: got %h want 0000000f", res); end
        start_op(3'd3, $urandom, $urandom);
        repeat (10) @(posedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (!(in_ready === 1'b1 && out_valid === 1'b0 && busy === 1'b0 && result === 32'h0)) begin
            n_err++; $display("FAIL rst_mid: got in_ready=%b out_valid=%b busy=%b result=%h want 1/0/0/0", in_ready, out_valid, busy, result);
        end
        a   = $urandom;
        b   = $urandom_range(1, 1000);
        exp = ref_model(3'd5, a, b);
        run_op(3'd5, a, b, res, lat, bok, hok);
        n_cmp++; if (res !== exp) begin n_err++; $display("FAIL rst_after_op: got %h want %h", res, exp); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  t_op;
        logic [31:0] a, b, res, exp;
        int          lat;
        bit          bok, hok;
        for (int i = 0; i < 8; i++) begin
            t_op = (i % 2 == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            a    = $urandom | 32'h8000_0000;
            b    = $urandom;
            exp  = ref_model(t_op, a, b);
            run_op(t_op, a, b, res, lat, bok, hok);
            n_cmp++; if (res !== exp) begin n_err++; $display("FAIL b2b_result[%0d] op=%0d: got %h want %h", i, t_op, res, exp); end
            n_cmp++; if (!bok) begin n_err++; $display("FAIL b2b_busy[%0d]: busy dropped while operation in flight", i); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
